lifo_fifo_buffer: RTL and testbench

Parametrised successor to the 4-bit/16-entry stack. A single storage array operates either as a LIFO (stack) or a FIFO (queue), chosen by a mode input. It adds occupancy count, a programmable threshold flag, burst drain and pass-through on simultaneous push/pop. It sits behind the debounce/edge-detector front end, so push, pop and burst_start arrive as single-cycle pulses.

---
 rtl/lifo_fifo_buffer.sv | 224 ++++++++++++++++++++++
 tb/tb_lifo_fifo_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_fifo_buffer.sv
// Dual-mode (stack/queue) register-array buffer with occupancy flags,
// programmable threshold, burst drain and push/pop pass-through.
module lifo_fifo_buffer #(
  parameter  int unsigned DATA_WIDTH = 4,
  parameter  int unsigned DEPTH      = 16,
  parameter  int unsigned THRESHOLD  = 12,
  localparam int unsigned CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mode_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic                  burst_start_i,
  input  logic [CW-1:0]         burst_len_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  valid_out_o,
  output logic                  busy_o,
  output logic [CW-1:0]         count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  threshold_o,
  output logic                  error_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         sp_q, sp_d;
  logic [CW-1:0]         remain_q, remain_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  cur_mode_q, cur_mode_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic                  full_q, empty_q, thr_q;

  logic                  is_empty, is_full, idle, mode_ld, eff_mode;
  logic                  pop_one, push_one, swap;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr, rd_addr, top_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [CW-1:0]         burst_clip;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign idle     = (state_q == ST_IDLE);
  // Mode is only switchable while nothing is stored; that cycle already uses the new mode.
  assign mode_ld  = is_empty && idle;
  assign eff_mode = mode_ld ? mode_i : cur_mode_q;

  assign top_idx    = AW'(sp_q - CW'(1));
  assign rd_addr    = eff_mode ? rd_ptr_q : top_idx;
  assign rd_data    = mem_q[rd_addr];
  assign burst_clip = (burst_len_i < count_q) ? burst_len_i : count_q;

  // Next-state, datapath control and registered-output values
  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    cur_mode_d = cur_mode_q;
    count_d    = count_q;
    sp_d       = sp_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    pop_one    = 1'b0;
    push_one   = 1'b0;
    swap       = 1'b0;

    if (mode_ld) begin
      cur_mode_d = mode_i;
    end else if ((mode_i != cur_mode_q) && !is_empty) begin
      error_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (burst_start_i && (burst_len_i != '0) && !is_empty) begin
          // First beat pops on the launch edge, so busy and valid_out align.
          state_d  = ST_BURST;
          pop_one  = 1'b1;
          remain_d = burst_clip - CW'(1);
          if (push_i) begin
            error_d = 1'b1;
          end
        end else if (push_i && pop_i) begin
          if (is_empty) begin
            data_out_d = data_in_i;
            valid_d    = 1'b1;
          end else begin
            swap = 1'b1;
          end
        end else if (push_i) begin
          if (is_full) begin
            error_d = 1'b1;
          end else begin
            push_one = 1'b1;
          end
        end else if (pop_i) begin
          if (is_empty) begin
            error_d = 1'b1;
          end else begin
            pop_one = 1'b1;
          end
        end
      end
      ST_BURST: begin
        if (push_i || pop_i || burst_start_i) begin
          error_d = 1'b1;
        end
        if (remain_q != '0) begin
          pop_one  = 1'b1;
          remain_d = remain_q - CW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (pop_one) begin
      data_out_d = rd_data;
      valid_d    = 1'b1;
      count_d    = count_q - CW'(1);
      if (eff_mode) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        sp_d = sp_q - CW'(1);
      end
    end

    if (push_one) begin
      mem_we  = 1'b1;
      count_d = count_q + CW'(1);
      if (eff_mode) begin
        mem_waddr = wr_ptr_q;
        wr_ptr_d  = wr_ptr_q + AW'(1);
      end else begin
        mem_waddr = AW'(sp_q);
        sp_d      = sp_q + CW'(1);
      end
    end

    // Simultaneous push/pop on a non-empty buffer: read old value, write new one.
    if (swap) begin
      data_out_d = rd_data;
      valid_d    = 1'b1;
      mem_we     = 1'b1;
      if (eff_mode) begin
        mem_waddr = wr_ptr_q;
        wr_ptr_d  = wr_ptr_q + AW'(1);
        rd_ptr_d  = rd_ptr_q + AW'(1);
      end else begin
        mem_waddr = top_idx;
      end
    end
  end

  // Control and status registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      remain_q   <= '0;
      cur_mode_q <= 1'b0;
      count_q    <= '0;
      sp_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      thr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      cur_mode_q <= cur_mode_d;
      count_q    <= count_d;
      sp_q       <= sp_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      full_q     <= (count_d == CW'(DEPTH));
      empty_q    <= (count_d == '0);
      thr_q      <= (count_d >= CW'(THRESHOLD));
    end
  end

  // Storage array; contents are meaningless once pointers reset
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= data_in_i;
    end
  end

  assign data_out_o  = data_out_q;
  assign valid_out_o = valid_q;
  assign busy_o      = (state_q == ST_BURST);
  assign count_o     = count_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign threshold_o = thr_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// Directed self-checking bench for lifo_fifo_buffer (default parameters).
module tb_lifo_fifo_buffer;

  logic       clk;
  logic       rst;
  logic       mode;
  logic       push;
  logic       pop;
  logic [3:0] data_in;
  logic       burst_start;
  logic [4:0] burst_len;
  logic [3:0] data_out;
  logic       valid_out;
  logic       busy;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       threshold;
  logic       error;

  int errors = 0;
  int checks = 0;

  lifo_fifo_buffer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mode_i        (mode),
    .push_i        (push),
    .pop_i         (pop),
    .data_in_i     (data_in),
    .burst_start_i (burst_start),
    .burst_len_i   (burst_len),
    .data_out_o    (data_out),
    .valid_out_o   (valid_out),
    .busy_o        (busy),
    .count_o       (count),
    .full_o        (full),
    .empty_o       (empty),
    .threshold_o   (threshold),
    .error_o       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic pu, input logic po, input logic bs,
                      input logic [3:0] d, input logic [4:0] bl);
    push        = pu;
    pop         = po;
    burst_start = bs;
    data_in     = d;
    burst_len   = bl;
    @(posedge clk);
    #1;
    push        = 1'b0;
    pop         = 1'b0;
    burst_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; push = 1'b0; pop = 1'b0;
    data_in = '0; burst_start = 1'b0; burst_len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_thr", 32'(threshold), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // LIFO ordering and underflow
    step(1, 0, 0, 4'd1, 0);
    step(1, 0, 0, 4'd2, 0);
    step(1, 0, 0, 4'd3, 0);
    chk("lifo_count3", 32'(count), 32'd3);
    step(0, 1, 0, 0, 0);
    chk("lifo_pop3", 32'(data_out), 32'd3);
    chk("lifo_pop3_v", 32'(valid_out), 32'd1);
    chk("lifo_cnt2", 32'(count), 32'd2);
    step(0, 1, 0, 0, 0);
    chk("lifo_pop2", 32'(data_out), 32'd2);
    chk("lifo_pop2_v", 32'(valid_out), 32'd1);
    step(0, 1, 0, 0, 0);
    chk("lifo_pop1", 32'(data_out), 32'd1);
    chk("lifo_cnt0", 32'(count), 32'd0);
    chk("lifo_empty", 32'(empty), 32'd1);
    step(0, 1, 0, 0, 0);
    chk("underflow_err", 32'(error), 32'd1);
    chk("underflow_v", 32'(valid_out), 32'd0);
    chk("underflow_hold", 32'(data_out), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("err_one_cycle", 32'(error), 32'd0);

    // FIFO fill, threshold, overflow, full swap and wrap
    mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 4'(i), 0);
      if (i == 10) chk("thr_at_11", 32'(threshold), 32'd0);
      if (i == 11) chk("thr_at_12", 32'(threshold), 32'd1);
    end
    chk("fifo_full", 32'(full), 32'd1);
    chk("fifo_cnt16", 32'(count), 32'd16);
    step(1, 0, 0, 4'hA, 0);
    chk("overflow_err", 32'(error), 32'd1);
    chk("overflow_cnt", 32'(count), 32'd16);
    step(1, 1, 0, 4'hA, 0);
    chk("full_swap_data", 32'(data_out), 32'd0);
    chk("full_swap_v", 32'(valid_out), 32'd1);
    chk("full_swap_cnt", 32'(count), 32'd16);
    chk("full_swap_err", 32'(error), 32'd0);
    for (int i = 1; i < 17; i++) begin
      step(0, 1, 0, 0, 0);
      chk("fifo_wrap_data", 32'(data_out), (i == 16) ? 32'hA : 32'(i));
    end
    chk("fifo_drain_empty", 32'(empty), 32'd1);
    chk("fifo_drain_full", 32'(full), 32'd0);

    // LIFO swap and empty pass-through
    mode = 1'b0;
    step(1, 0, 0, 4'd5, 0);
    step(1, 0, 0, 4'd6, 0);
    step(1, 1, 0, 4'd9, 0);
    chk("lifo_swap_data", 32'(data_out), 32'd6);
    chk("lifo_swap_cnt", 32'(count), 32'd2);
    step(0, 1, 0, 0, 0);
    chk("lifo_after_swap", 32'(data_out), 32'd9);
    step(0, 1, 0, 0, 0);
    chk("lifo_bottom", 32'(data_out), 32'd5);
    step(1, 1, 0, 4'd7, 0);
    chk("pass_data", 32'(data_out), 32'd7);
    chk("pass_v", 32'(valid_out), 32'd1);
    chk("pass_cnt", 32'(count), 32'd0);
    chk("pass_err", 32'(error), 32'd0);

    // FIFO burst clipped to occupancy, pop injected mid-burst
    mode = 1'b1;
    for (int i = 1; i < 5; i++) step(1, 0, 0, 4'(i), 0);
    step(0, 0, 1, 0, 5'd10);
    chk("burst_b1_busy", 32'(busy), 32'd1);
    chk("burst_b1_data", 32'(data_out), 32'd1);
    chk("burst_b1_v", 32'(valid_out), 32'd1);
    chk("burst_b1_err", 32'(error), 32'd0);
    step(0, 1, 0, 0, 0);
    chk("burst_pop_err", 32'(error), 32'd1);
    chk("burst_b2_data", 32'(data_out), 32'd2);
    chk("burst_b2_cnt", 32'(count), 32'd2);
    step(0, 0, 0, 0, 0);
    chk("burst_b3_data", 32'(data_out), 32'd3);
    chk("burst_b3_busy", 32'(busy), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("burst_b4_data", 32'(data_out), 32'd4);
    chk("burst_b4_busy", 32'(busy), 32'd1);
    chk("burst_b4_empty", 32'(empty), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("burst_end_busy", 32'(busy), 32'd0);
    chk("burst_end_v", 32'(valid_out), 32'd0);
    step(0, 0, 1, 0, 5'd0);
    chk("burst_len0_busy", 32'(busy), 32'd0);
    chk("burst_empty_err", 32'(error), 32'd0);

    // Mode change refused while occupied
    mode = 1'b0;
    step(1, 0, 0, 4'd3, 0);
    step(1, 0, 0, 4'd4, 0);
    mode = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("mode_busy_err", 32'(error), 32'd1);
    mode = 1'b0;
    step(0, 1, 0, 0, 0);
    chk("mode_held_lifo", 32'(data_out), 32'd4);
    chk("mode_held_err", 32'(error), 32'd0);
    step(0, 1, 0, 0, 0);
    chk("mode_drain", 32'(data_out), 32'd3);
    mode = 1'b1;
    step(1, 0, 0, 4'd1, 0);
    step(1, 0, 0, 4'd2, 0);
    step(0, 1, 0, 0, 0);
    chk("mode_fifo_ok", 32'(data_out), 32'd1);
    chk("mode_fifo_err", 32'(error), 32'd0);

    // Asynchronous reset mid-burst
    step(1, 0, 0, 4'd5, 0);
    step(1, 0, 0, 4'd6, 0);
    step(0, 0, 1, 0, 5'd3);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_data", 32'(data_out), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(valid_out), 32'd0);
    chk("arst_data", 32'(data_out), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    mode = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 4'd8, 0);
    chk("post_rst_cnt", 32'(count), 32'd1);
    step(0, 1, 0, 0, 0);
    chk("post_rst_data", 32'(data_out), 32'd8);
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
